// File: rtl/meter_compositor_if.sv
// Video-side bundle for meter_compositor: raw timing and sprite pixels in,
// composited RGB, realigned sync and frame status out.
interface meter_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic                       hsync_in;
    logic                       vsync_in;
    logic                       blank_in;
    logic [NUM_LAYERS*24-1:0]   layer_pixels;
    logic [23:0]                bg_color;
    logic [NUM_LAYERS-1:0]      flash_mask;
    logic [23:0]                rgb;
    logic                       hsync_out;
    logic                       vsync_out;
    logic                       blank_out;
    logic [7:0]                 frame_count;
    logic                       frame_tick;

    modport master (
        output hsync_in, vsync_in, blank_in, layer_pixels, bg_color, flash_mask,
        input  rgb, hsync_out, vsync_out, blank_out, frame_count, frame_tick
    );
    modport slave (
        input  hsync_in, vsync_in, blank_in, layer_pixels, bg_color, flash_mask,
        output rgb, hsync_out, vsync_out, blank_out, frame_count, frame_tick
    );
endinterface

// File: rtl/meter_compositor.sv
// Fixed-priority sprite compositor with sync realignment and frame counter.
// Optional layer flashing is built only when METER_FLASH_EN is defined.
module meter_compositor #(
    parameter int NUM_LAYERS   = 4,
    parameter int SYNC_DELAY   = 3,
    parameter int FLASH_PERIOD = 30
) (
    input  logic               pixel_clk,
    input  logic               reset,
    meter_compositor_if.slave  vif
);
    logic [SYNC_DELAY-1:0] hsync_pipe_q, hsync_pipe_d;
    logic [SYNC_DELAY-1:0] vsync_pipe_q, vsync_pipe_d;
    logic [SYNC_DELAY-1:0] blank_pipe_q, blank_pipe_d;
    logic [23:0]           rgb_q, rgb_d;
    logic                  vsync_prev_q, vsync_prev_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [7:0]            frame_count_q, frame_count_d;
    logic                  vsync_rise;
    logic [NUM_LAYERS-1:0] suppress;
    logic [23:0]           comp;

    assign vsync_rise = vif.vsync_in & ~vsync_prev_q;

`ifdef METER_FLASH_EN
    localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_phase_q, flash_phase_d;

    always_comb begin
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        if (vsync_rise) begin
            if (flash_cnt_q == FW'(FLASH_PERIOD - 1)) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FW'(1);
            end
        end
        suppress = flash_phase_q ? vif.flash_mask : '0;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end
`else
    logic unused_flash_mask;
    assign unused_flash_mask = ^vif.flash_mask;
    assign suppress          = '0;
`endif

    always_comb begin
        hsync_pipe_d    = hsync_pipe_q;
        vsync_pipe_d    = vsync_pipe_q;
        blank_pipe_d    = blank_pipe_q;
        hsync_pipe_d[0] = vif.hsync_in;
        vsync_pipe_d[0] = vif.vsync_in;
        blank_pipe_d[0] = vif.blank_in;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            hsync_pipe_d[i] = hsync_pipe_q[i-1];
            vsync_pipe_d[i] = vsync_pipe_q[i-1];
            blank_pipe_d[i] = blank_pipe_q[i-1];
        end

        // Walk from lowest priority upward so the lowest qualifying index wins.
        comp = vif.bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vif.layer_pixels[24*i +: 24] != 24'h0 && !suppress[i])
                comp = vif.layer_pixels[24*i +: 24];
        end

        // Gate with the blank value entering the last stage so rgb and blank_out
        // land on the same cycle.
        rgb_d = blank_pipe_d[SYNC_DELAY-1] ? 24'h0 : comp;

        vsync_prev_d  = vif.vsync_in;
        frame_tick_d  = vsync_rise;
        frame_count_d = vsync_rise ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hsync_pipe_q  <= '0;
            vsync_pipe_q  <= '0;
            blank_pipe_q  <= '1;
            rgb_q         <= '0;
            vsync_prev_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hsync_pipe_q  <= hsync_pipe_d;
            vsync_pipe_q  <= vsync_pipe_d;
            blank_pipe_q  <= blank_pipe_d;
            rgb_q         <= rgb_d;
            vsync_prev_q  <= vsync_prev_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vif.rgb         = rgb_q;
    assign vif.hsync_out   = hsync_pipe_q[SYNC_DELAY-1];
    assign vif.vsync_out   = vsync_pipe_q[SYNC_DELAY-1];
    assign vif.blank_out   = blank_pipe_q[SYNC_DELAY-1];
    assign vif.frame_count = frame_count_q;
    assign vif.frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_meter_compositor.sv
// Directed bench for meter_compositor: a history-based model checked every
// cycle, plus literal expectations at the interesting points.
module tb_meter_compositor;
    localparam int NL = 4;
    localparam int SD = 3;
    localparam int FP = 2;
    localparam int N  = 8192;

    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;

    meter_compositor_if #(.NUM_LAYERS(NL)) vif ();
    meter_compositor #(.NUM_LAYERS(NL), .SYNC_DELAY(SD), .FLASH_PERIOD(FP)) dut (
        .pixel_clk(pixel_clk),
        .reset    (reset),
        .vif      (vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Input history, one entry per rising edge as the DUT sampled it.
    bit                  r_h [N];
    bit                  h_h [N];
    bit                  v_h [N];
    bit                  b_h [N];
    int                  n = 0;
    int                  ticks = 0;
    bit                  exp_h, exp_v, exp_b, exp_tick;
    logic [23:0]         exp_rgb;
    logic [7:0]          exp_fc;

    function automatic logic [23:0] composite(input logic [NL*24-1:0] px, input logic [23:0] bg,
                                              input logic [NL-1:0] mask, input bit phase);
        for (int i = 0; i < NL; i++) begin
            logic [23:0] p;
            p = px[24*i +: 24];
            if (p != 24'h0 && !(phase && mask[i])) return p;
        end
        return bg;
    endfunction

    always @(posedge pixel_clk) begin
        bit rw;
        bit phase;
        bit prev;
        int k0;
        n++;
        if (n >= N) begin
            $display("FAIL history: cycle budget %0d exceeded", N);
            $fatal(1);
        end
        r_h[n] = reset;
        h_h[n] = vif.hsync_in;
        v_h[n] = vif.vsync_in;
        b_h[n] = vif.blank_in;
`ifdef METER_FLASH_EN
        phase = ((ticks / FP) % 2) == 1;
`else
        phase = 1'b0;
`endif
        rw = 1'b0;
        for (int k = n - SD + 1; k <= n; k++)
            if (k < 1 || r_h[k]) rw = 1'b1;
        k0 = n - SD + 1;
        if (rw) begin
            exp_h = 1'b0; exp_v = 1'b0; exp_b = 1'b1;
        end else begin
            exp_h = h_h[k0]; exp_v = v_h[k0]; exp_b = b_h[k0];
        end
        exp_rgb = exp_b ? 24'h0 : composite(vif.layer_pixels, vif.bg_color, vif.flash_mask, phase);
        if (r_h[n]) begin
            ticks    = 0;
            exp_tick = 1'b0;
        end else begin
            prev     = (n < 2 || r_h[n-1]) ? 1'b0 : v_h[n-1];
            exp_tick = v_h[n] && !prev;
            if (exp_tick) ticks++;
        end
        exp_fc = 8'(ticks % 256);
    end

    always @(negedge pixel_clk) begin
        if (n >= 1) begin
            check("rgb",         {8'h0, vif.rgb},         {8'h0, exp_rgb});
            check("hsync_out",   {31'h0, vif.hsync_out},  {31'h0, exp_h});
            check("vsync_out",   {31'h0, vif.vsync_out},  {31'h0, exp_v});
            check("blank_out",   {31'h0, vif.blank_out},  {31'h0, exp_b});
            check("frame_count", {24'h0, vif.frame_count}, {24'h0, exp_fc});
            check("frame_tick",  {31'h0, vif.frame_tick}, {31'h0, exp_tick});
        end
    end

    task automatic cyc();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_layers(input logic [23:0] l0, l1, l2, l3);
        vif.layer_pixels = {l3, l2, l1, l0};
    endtask

    initial begin
        int tick_cnt;
        logic [23:0] flash_exp;
        vif.hsync_in   = 1'b0;
        vif.vsync_in   = 1'b0;
        vif.blank_in   = 1'b0;
        vif.bg_color   = 24'h0;
        vif.flash_mask = '0;
        set_layers(24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);

        // Reset dominates live inputs.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rst_rgb",   {8'h0, vif.rgb},          32'h0);
            check("rst_blank", {31'h0, vif.blank_out},   32'h1);
            check("rst_fc",    {24'h0, vif.frame_count}, 32'h0);
        end
        reset = 1'b0;
        cyc(); check("rel1_blank", {31'h0, vif.blank_out}, 32'h1);
        cyc(); check("rel2_blank", {31'h0, vif.blank_out}, 32'h1);
               check("rel2_rgb",   {8'h0, vif.rgb},        32'h0);
        cyc(); check("rel3_blank", {31'h0, vif.blank_out}, 32'h0);
               check("rel3_rgb",   {8'h0, vif.rgb},        32'hFF0000);

        // Priority.
        set_layers(24'h0, 24'h00FF00, 24'hFF0000, 24'h0);
        vif.bg_color = 24'h101010;
        cyc(); check("prio_l1", {8'h0, vif.rgb}, 32'h00FF00);
        set_layers(24'h0, 24'h0, 24'h0, 24'h0);
        cyc(); check("prio_bg", {8'h0, vif.rgb}, 32'h101010);
        vif.bg_color = 24'h0;
        cyc(); check("prio_zero", {8'h0, vif.rgb}, 32'h0);

        // Latency of each sync line.
        vif.hsync_in = 1'b1; cyc(); vif.hsync_in = 1'b0;
        check("hs_d0", {31'h0, vif.hsync_out}, 32'h0);
        cyc(); check("hs_d1", {31'h0, vif.hsync_out}, 32'h0);
        cyc(); check("hs_d2", {31'h0, vif.hsync_out}, 32'h1);
        cyc(); check("hs_d3", {31'h0, vif.hsync_out}, 32'h0);
        vif.vsync_in = 1'b1; cyc(); vif.vsync_in = 1'b0;
        cyc(); check("vs_d1", {31'h0, vif.vsync_out}, 32'h0);
        cyc(); check("vs_d2", {31'h0, vif.vsync_out}, 32'h1);
        cyc(); check("vs_d3", {31'h0, vif.vsync_out}, 32'h0);

        // Blank pulse gates rgb exactly where blank_out is high.
        set_layers(24'hFFFFFF, 24'h0, 24'h0, 24'h0);
        vif.blank_in = 1'b1; cyc(); vif.blank_in = 1'b0;
        cyc(); check("bl_d1_rgb", {8'h0, vif.rgb},        32'hFFFFFF);
        cyc(); check("bl_d2",     {31'h0, vif.blank_out}, 32'h1);
               check("bl_d2_rgb", {8'h0, vif.rgb},        32'h0);
        cyc(); check("bl_d3_rgb", {8'h0, vif.rgb},        32'hFFFFFF);

        // Mid-stream reset, then 257 four-cycle vsync pulses.
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        tick_cnt = 0;
        for (int p = 0; p < 257; p++) begin
            vif.vsync_in = 1'b1;
            for (int c = 0; c < 4; c++) begin cyc(); if (vif.frame_tick) tick_cnt++; end
            vif.vsync_in = 1'b0;
            for (int c = 0; c < 4; c++) begin cyc(); if (vif.frame_tick) tick_cnt++; end
        end
        check("tick_total", tick_cnt, 257);
        check("fc_wrap", {24'h0, vif.frame_count}, 32'h1);

        // Flash sequencing across six frames.
        reset = 1'b1; cyc(); reset = 1'b0;
        vif.flash_mask = 4'b0001;
        set_layers(24'h0000FF, 24'h00FF00, 24'h0, 24'h0);
        for (int c = 0; c < SD + 1; c++) cyc();
        for (int f = 0; f < 6; f++) begin
`ifdef METER_FLASH_EN
            flash_exp = ((f / 2) % 2 == 1) ? 24'h00FF00 : 24'h0000FF;
`else
            flash_exp = 24'h0000FF;
`endif
            check("flash_fc",  {24'h0, vif.frame_count}, f);
            check("flash_rgb", {8'h0, vif.rgb},          {8'h0, flash_exp});
            vif.vsync_in = 1'b1; cyc(); cyc();
            vif.vsync_in = 1'b0;
            for (int c = 0; c < 6; c++) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
